kbd_history_7seg: RTL

- Parametrised successor to the fixed 4-byte keyboard scan-code viewer.
- Stores the last DEPTH bytes from the PS/2 byte stream (ps2_kbd ready/data) in a circular history and shows a scrollable window of NDIG/2 bytes as hex on an NDIG-digit multiplexed 7-segment display.
- Adds freeze, clear, scrolling, fill tracking and blanking of empty entries.
- Sits between ps2_kbd and the board's SEG/AN pins.

---
 rtl/kbd_disp_pkg.sv | 21 ++
 rtl/kbd_history_7seg_hex_to_seg.sv | 19 +
 rtl/kbd_history_7seg.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/kbd_disp_pkg.sv
// ============================================================================
// Module : kbd_disp_pkg
// Brief  : Shared constants for the keyboard history 7-segment viewer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package kbd_disp_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/kbd_history_7seg_hex_to_seg.sv
// ============================================================================
// Module : hex_to_seg
// Brief  : Combinational nibble to active-low 7-segment pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hex_to_seg
  import kbd_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/kbd_history_7seg.sv
// ============================================================================
// Module : kbd_history_7seg
// Brief  : Circular history of PS/2 bytes shown as a scrollable hex window on
//          a multiplexed 7-segment display. Define KBD_BREAK_FILTER_EN to drop
//          F0 break prefixes together with the byte that follows them.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module kbd_history_7seg
  import kbd_disp_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  input  logic                         freeze,
  input  logic                         scroll_up,
  input  logic                         scroll_dn,
  input  logic                         clear,
  output logic [7:0]                   SEG,
  output logic [NDIG-1:0]              AN,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int FW     = $clog2(DEPTH + 1);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int MAXOFF = DEPTH - NDIG / 2;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [FW-1:0]   r_fill;
  logic [FW-1:0]   r_off;
  logic [PW-1:0]   r_presc;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_seg;
  logic [NDIG-1:0] r_an;

  logic            w_acc;
  logic            w_store;
  logic            w_tick;
  logic [IW-1:0]   w_idx_nxt;
  logic [FW-1:0]   w_age;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_byte;
  logic [3:0]      w_nib;
  logic [6:0]      w_pat;
  logic            w_blank;
  logic            w_dp_on;
  logic            w_up;
  logic            w_dn;
  logic            w_sticky;
  logic [FW:0]     w_sum;
  logic [FW-1:0]   w_off_nxt;

  assign SEG  = r_seg;
  assign AN   = r_an;
  assign fill = r_fill;

  assign w_acc = byte_valid & ~freeze & ~clear;

`ifdef KBD_BREAK_FILTER_EN
  logic r_pend;

  // A pending break prefix swallows the next accepted byte, whatever it is.
  assign w_store = w_acc & ~r_pend & (byte_data != BREAK_CODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pend <= 1'b0;
    else if (clear)
      r_pend <= 1'b0;
    else if (w_acc)
      r_pend <= ~r_pend & (byte_data == BREAK_CODE);
  end
`else
  assign w_store = w_acc;
`endif

  always_ff @(posedge clk) begin
    if (w_store)
      r_mem[r_wptr] <= byte_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_store)
        r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      if (clear)
        r_fill <= '0;
      else if (w_store && (r_fill != FW'(DEPTH)))
        r_fill <= r_fill + FW'(1);
    end
  end

  assign w_up     = scroll_up & ~scroll_dn;
  assign w_dn     = scroll_dn & ~scroll_up;
  assign w_sticky = w_store & (r_off != '0);
  assign w_sum    = {1'b0, r_off} + (FW+1)'(w_up) + (FW+1)'(w_sticky);

  // Net step is -1..+2; a down pulse and a sticky bump cancel out.
  always_comb begin
    w_off_nxt = r_off;
    if (clear)
      w_off_nxt = '0;
    else if (w_dn)
      w_off_nxt = (w_sticky || (r_off == '0)) ? r_off : r_off - FW'(1);
    else if (w_sum > (FW+1)'(MAXOFF))
      w_off_nxt = FW'(MAXOFF);
    else
      w_off_nxt = w_sum[FW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_off <= '0;
    else
      r_off <= w_off_nxt;
  end

  assign w_tick    = (r_presc == PW'(SCAN_DIV - 1));
  assign w_idx_nxt = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);

  // Digit pair k shows age offset+k; address walks back from the newest slot.
  assign w_age   = r_off + FW'(w_idx_nxt >> 1);
  assign w_addr  = (r_wptr - AW'(1) - AW'(w_age)) & AW'(DEPTH - 1);
  assign w_byte  = r_mem[w_addr];
  assign w_nib   = w_idx_nxt[0] ? w_byte[7:4] : w_byte[3:0];
  assign w_blank = (w_age >= r_fill);
  assign w_dp_on = (w_idx_nxt == IW'(NDIG - 1)) && (r_off != '0);

  hex_to_seg u_hex (
    .i_nibble (w_nib),
    .o_seg    (w_pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= w_idx_nxt;
      r_an    <= ~(NDIG'(1) << w_idx_nxt);
      r_seg   <= w_blank ? SEG_BLANK : {~w_dp_on, w_pat};
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

endmodule

`default_nettype wire
